pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Second-generation control unit for the 5-stage RV32 pipeline. It decodes the ID-stage instruction into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and applies hold, flush and bubble insertion. It extends the ALU-op and immediate encodings to cover LUI, AUIPC and shifts, with optional RV32M.

Parameters:
OP_W, 5, ALU operation width; must be ≥4, and ≥5 when RV32M_EN is defined (elaboration-time check).
HAZARD_EN, 1, 1 = internal load-use detection active; 0 = hazard_stall tied 0.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_id  in  32  instruction in ID stage
id_valid  in  1  instr_id is a real instruction
hold  in  1  global freeze; no stage register updates
flush_id  in  1  taken branch/jump resolved in EX; squash the ID instruction
id_imm_src  out  3  immediate format for ID: I=0, S=1, B=2, J=3, U=4
id_illegal  out  1  id_valid with an unsupported encoding
hazard_stall  out  1  load-use stall request to PC and IF/ID
ex_valid, ex_alu_src, ex_alu_a_pc, ex_branch, ex_jump, ex_mem_read  out  1 each  EX-stage controls
ex_alu_op  out  OP_W  EX ALU operation
ex_funct3  out  3  branch condition select
ex_rd  out  5  EX destination register
mem_valid, mem_mem_read, mem_mem_write  out  1 each  MEM-stage controls
mem_rd  out  5  MEM destination register
wb_valid, wb_reg_write  out  1 each  WB-stage controls
wb_result_src  out  2  WB result select: 0 = ALU, 1 = memory, 2 = PC+4
wb_rd  out  5  WB destination register

Behaviour:
- Decode is combinational in ID. Supported opcodes: LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC.
- ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10.
  - SUB applies to OP with funct7[5]=1 only.
  - SRA applies to OP/OP-IMM with funct3=101 and funct7[5]=1.
  - LUI decodes to PASSB.
  - AUIPC decodes to ADD with ex_alu_a_pc=1.
  - Loads, stores, JAL and JALR decode to ADD.
  - Branches decode to SUB, with funct3 passed on in ex_funct3.
- Illegal or unsupported encodings: id_illegal=1 and the bundle becomes a bubble (all enables 0, valid 0).
- reg_write is forced to 0 whenever rd=0.
- Latency: ID decode appears on ex_* one cycle later, mem_* two cycles later, wb_* three cycles later.
- Load-use hazard condition:
  - HAZARD_EN, id_valid, ex_valid and ex_mem_read are all 1, ex_rd≠0, and the ID instruction uses a matching source.
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR. rs2 is used by OP, STORE, BRANCH.
  - The hazard drives hazard_stall=1 combinationally, even while hold=1.
- Per-edge update priority:
  1. hold=1: all stage registers keep their values. flush_id is ignored; the source keeps it asserted until hold drops.
  2. flush_id=1: ID/EX loads a bubble and hazard_stall is don't-care. EX/MEM and MEM/WB advance.
  3. Hazard: ID/EX loads a bubble and EX/MEM and MEM/WB advance. The same ID instruction is re-decoded next cycle, after which the hazard has cleared.
  4. Otherwise: ID/EX loads the decoded bundle (bubble if !id_valid). EX/MEM and MEM/WB shift.
- Reset (asynchronous assert, synchronous-safe deassert by top level): every registered output is 0, including valids, enables, ex_alu_op, rd fields and wb_result_src. Reset mid-pipeline discards all in-flight bundles.
- Bubbles carry rd=0 and alu_op=ADD.

Optional Feature:
RV32M_EN
- Defined: OP with funct7=0000001 decodes to ALU op 16+funct3 (MUL…REMU = 16…23), with reg_write=1 and result_src=ALU.
- Undefined: that encoding sets id_illegal and produces a bubble.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants;
  - ALU op encodings (including the M range);
  - ImmSrc and ResultSrc encodings;
  - ctrl_bundle_t struct (valid, alu_src, alu_a_pc, alu_op, funct3, branch, jump, mem_read, mem_write, reg_write, result_src, rd);
  - BUBBLE constant.
- One sub-module, ctrl_decoder: purely combinational, instr → ctrl_bundle_t, imm_src, illegal, rs1_used, rs2_used. Instantiated once.
- Pipeline registers and hazard logic live in pipe_ctrl_unit.

Test Plan:
- Reset then `add x3,x1,x2` with id_valid=1 → next cycle ex_alu_op=0, ex_rd=3; two cycles later wb_reg_write=1, wb_result_src=0, wb_rd=3.
- `lw x5,0(x1)` then `add x6,x5,x2` → hazard_stall=1 for exactly one cycle, ex_valid=0 that cycle; the add reaches EX one cycle later. Repeat with rd=x0 → no stall.
- Branch in EX with flush_id=1 → bubble enters EX (ex_valid=0); the preceding branch continues to MEM with mem_mem_write=0.
- hold=1 for 3 cycles with sw in MEM → mem_mem_write stays 1 and wb_* unchanged throughout; flush_id asserted during hold has no effect.
- `lui x7,0x12345` → id_imm_src=4, ex_alu_op=10. `auipc` → ex_alu_a_pc=1. `sra x1,x2,x3` → ex_alu_op=7. Opcode 0x7F → id_illegal=1 with a bubble.
- `mul x1,x2,x3`: with RV32M_EN → ex_alu_op=16; without → id_illegal=1. rst_n pulsed low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared encodings for the RV32 pipeline control unit: opcodes, ALU ops
// (base and M range), immediate/result selects and the per-stage bundles.
// RV32M_EN enables the M-extension ALU op range in the decoder.
package ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    logic        valid;
    logic        alu_src;
    logic        alu_a_pc;
    alu_op_e     alu_op;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    result_src_e result_src;
    logic [4:0]  rd;
  } ctrl_bundle_t;

  // Later stages only carry what they still act on.
  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    result_src_e result_src;
    logic [4:0]  rd;
  } mem_bundle_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    result_src_e result_src;
    logic [4:0]  rd;
  } wb_bundle_t;

  localparam ctrl_bundle_t BUBBLE     = '{alu_op: ALU_ADD, result_src: RES_ALU, default: '0};
  localparam mem_bundle_t  MEM_BUBBLE = '{result_src: RES_ALU, default: '0};
  localparam wb_bundle_t   WB_BUBBLE  = '{result_src: RES_ALU, default: '0};

  // Base ALU op selected by funct3 for OP / OP-IMM with funct7 = 0.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage inputs and per-stage control outputs of pipe_ctrl_unit.
// master drives the ID side (pipeline front end); slave is the control unit.
interface pipe_ctrl_unit_if #(
  parameter int unsigned OP_W = 5
);
  logic [31:0]     instr_id;
  logic            id_valid;
  logic            hold;
  logic            flush_id;
  logic [2:0]      id_imm_src;
  logic            id_illegal;
  logic            hazard_stall;
  logic            ex_valid;
  logic            ex_alu_src;
  logic            ex_alu_a_pc;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_mem_read;
  logic [OP_W-1:0] ex_alu_op;
  logic [2:0]      ex_funct3;
  logic [4:0]      ex_rd;
  logic            mem_valid;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic [4:0]      mem_rd;
  logic            wb_valid;
  logic            wb_reg_write;
  logic [1:0]      wb_result_src;
  logic [4:0]      wb_rd;

  modport master (
    output instr_id, id_valid, hold, flush_id,
    input  id_imm_src, id_illegal, hazard_stall,
    input  ex_valid, ex_alu_src, ex_alu_a_pc, ex_branch, ex_jump, ex_mem_read,
    input  ex_alu_op, ex_funct3, ex_rd,
    input  mem_valid, mem_mem_read, mem_mem_write, mem_rd,
    input  wb_valid, wb_reg_write, wb_result_src, wb_rd
  );

  modport slave (
    input  instr_id, id_valid, hold, flush_id,
    output id_imm_src, id_illegal, hazard_stall,
    output ex_valid, ex_alu_src, ex_alu_a_pc, ex_branch, ex_jump, ex_mem_read,
    output ex_alu_op, ex_funct3, ex_rd,
    output mem_valid, mem_mem_read, mem_mem_write, mem_rd,
    output wb_valid, wb_reg_write, wb_result_src, wb_rd
  );
endinterface

// File: rtl/pipe_ctrl_unit_decoder.sv
// Combinational ID-stage decoder: instruction -> control bundle, immediate
// format, illegal flag and source-register usage. RV32M_EN adds MUL..REMU.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output imm_src_e     imm_src,
  output logic         illegal,
  output logic         rs1_used,
  output logic         rs2_used
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       legal;
  logic       writes;
  logic       unused_rs_fields;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register source fields are compared against EX in the top level.
  assign unused_rs_fields = ^instr[24:15];

  // Classify opcode, pick ALU op / enables, then squash to a bubble if illegal.
  always_comb begin
    ctrl     = BUBBLE;
    imm_src  = IMM_I;
    legal    = 1'b1;
    writes   = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        legal           = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.result_src = RES_MEM;
        writes          = 1'b1;
        rs1_used        = 1'b1;
      end
      OPC_STORE: begin
        legal          = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        imm_src        = IMM_S;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_OP: begin
        writes   = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        if (funct7 == F7_BASE)
          ctrl.alu_op = alu_from_funct3(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)
          ctrl.alu_op = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
          ctrl.alu_op = ALU_SRA;
`ifdef RV32M_EN
        else if (funct7 == F7_MULDIV)
          ctrl.alu_op = alu_op_e'({2'b10, funct3});
`endif
        else
          legal = 1'b0;
      end
      OPC_OP_IMM: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = alu_from_funct3(funct3);
        writes       = 1'b1;
        rs1_used     = 1'b1;
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
        end
      end
      OPC_BRANCH: begin
        legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
        imm_src     = IMM_B;
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      OPC_JAL: begin
        imm_src         = IMM_J;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_a_pc   = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        writes          = 1'b1;
      end
      OPC_JALR: begin
        legal           = (funct3 == 3'b000);
        ctrl.alu_src    = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        writes          = 1'b1;
        rs1_used        = 1'b1;
      end
      OPC_LUI: begin
        imm_src      = IMM_U;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_PASSB;
        writes       = 1'b1;
      end
      OPC_AUIPC: begin
        imm_src       = IMM_U;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_a_pc = 1'b1;
        writes        = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      ctrl.valid     = 1'b1;
      ctrl.funct3    = funct3;
      ctrl.reg_write = writes && (rd != 5'd0);
      ctrl.rd        = writes ? rd : 5'd0;
    end else begin
      ctrl     = BUBBLE;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
    end
    illegal = !legal;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Control unit for the 5-stage RV32 pipeline: ID decode, ID/EX, EX/MEM and
// MEM/WB control registers, load-use hazard detection, hold/flush/bubble.
// RV32M_EN (macro) enables the M-extension decode and requires OP_W >= 5.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 5,
  parameter int unsigned HAZARD_EN = 1
) (
  input logic            clk,
  input logic            rst_n,
  pipe_ctrl_unit_if.slave bus
);

`ifdef RV32M_EN
  localparam int unsigned OP_W_MIN = 5;
`else
  localparam int unsigned OP_W_MIN = 4;
`endif

  if (OP_W < OP_W_MIN) begin : g_op_w_check
    $error("pipe_ctrl_unit: OP_W too narrow for the ALU op encoding");
  end

  ctrl_bundle_t dec_ctrl;
  imm_src_e     dec_imm_src;
  logic         dec_illegal;
  logic         dec_rs1_used;
  logic         dec_rs2_used;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         load_use;

  ctrl_bundle_t idex;
  mem_bundle_t  exmem;
  wb_bundle_t   memwb;

  ctrl_decoder u_decoder (
    .instr    (bus.instr_id),
    .ctrl     (dec_ctrl),
    .imm_src  (dec_imm_src),
    .illegal  (dec_illegal),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used)
  );

  assign rs1 = bus.instr_id[19:15];
  assign rs2 = bus.instr_id[24:20];

  // Load in EX whose destination feeds a source the ID instruction reads.
  always_comb begin
    load_use = 1'b0;
    if (HAZARD_EN != 0 && bus.id_valid && idex.valid && idex.mem_read && idex.rd != 5'd0)
      load_use = (dec_rs1_used && rs1 == idex.rd) || (dec_rs2_used && rs2 == idex.rd);
  end

  // ID/EX: hold freezes; flush, hazard or no instruction inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idex <= BUBBLE;
    else if (!bus.hold) begin
      if (bus.flush_id || load_use || !bus.id_valid)
        idex <= BUBBLE;
      else
        idex <= dec_ctrl;
    end
  end

  // EX/MEM and MEM/WB advance on every edge that is not held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem <= MEM_BUBBLE;
      memwb <= WB_BUBBLE;
    end else if (!bus.hold) begin
      exmem <= '{valid: idex.valid, mem_read: idex.mem_read, mem_write: idex.mem_write,
                 reg_write: idex.reg_write, result_src: idex.result_src, rd: idex.rd};
      memwb <= '{valid: exmem.valid, reg_write: exmem.reg_write,
                 result_src: exmem.result_src, rd: exmem.rd};
    end
  end

  assign bus.id_imm_src    = dec_imm_src;
  assign bus.id_illegal    = bus.id_valid && dec_illegal;
  assign bus.hazard_stall  = load_use;

  assign bus.ex_valid      = idex.valid;
  assign bus.ex_alu_src    = idex.alu_src;
  assign bus.ex_alu_a_pc   = idex.alu_a_pc;
  assign bus.ex_branch     = idex.branch;
  assign bus.ex_jump       = idex.jump;
  assign bus.ex_mem_read   = idex.mem_read;
  assign bus.ex_alu_op     = OP_W'(idex.alu_op);
  assign bus.ex_funct3     = idex.funct3;
  assign bus.ex_rd         = idex.rd;

  assign bus.mem_valid     = exmem.valid;
  assign bus.mem_mem_read  = exmem.mem_read;
  assign bus.mem_mem_write = exmem.mem_write;
  assign bus.mem_rd        = exmem.rd;

  assign bus.wb_valid      = memwb.valid;
  assign bus.wb_reg_write  = memwb.reg_write;
  assign bus.wb_result_src = memwb.result_src;
  assign bus.wb_rd         = memwb.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: the driver computes expectations from
// an instruction-level reference model and queues them; the monitor compares.
// Honours RV32M_EN for the M-extension expectations.
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.OP_W(5)) bus_if();

  pipe_ctrl_unit #(.OP_W(5), .HAZARD_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    bit valid, alu_src, a_pc, branch, jump, mem_read, mem_write, reg_write;
    int alu_op, funct3, result_src, rd;
  } stage_t;

  typedef struct {
    bit     legal;
    int     imm;
    bit     u1, u2;
    stage_t b;
  } dec_t;

  typedef struct {
    bit     chk_stall, stall, illegal;
    int     imm;
    stage_t ex, mem, wb;
  } sb_t;

  sb_t    sbq[$];
  stage_t pm[3];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     f3_alu[8] = '{0, 5, 8, 9, 4, 6, 3, 2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic stage_t bubble();
    stage_t s;
    return s;
  endfunction

  // Instruction-level reference: what each RV32 instruction asks of the pipeline.
  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t e;
    int   op, f3, f7, rd;
    bit   wr;
    op = int'(i[6:0]); f3 = int'(i[14:12]); f7 = int'(i[31:25]); rd = int'(i[11:7]);
    e.legal = 1; wr = 0;
    case (op)
      'h03: begin e.legal = !(f3 inside {3, 6, 7}); e.b.alu_src = 1; e.b.mem_read = 1;
                  e.b.result_src = 1; wr = 1; e.u1 = 1; end
      'h23: begin e.legal = (f3 < 3); e.imm = 1; e.b.alu_src = 1; e.b.mem_write = 1;
                  e.u1 = 1; e.u2 = 1; end
      'h33: begin
        wr = 1; e.u1 = 1; e.u2 = 1;
        if (f7 == 0) e.b.alu_op = f3_alu[f3];
        else if (f7 == 'h20 && f3 == 0) e.b.alu_op = 1;
        else if (f7 == 'h20 && f3 == 5) e.b.alu_op = 7;
`ifdef RV32M_EN
        else if (f7 == 1) e.b.alu_op = 16 + f3;
`endif
        else e.legal = 0;
      end
      'h13: begin
        wr = 1; e.u1 = 1; e.b.alu_src = 1; e.b.alu_op = f3_alu[f3];
        if (f3 == 1) e.legal = (f7 == 0);
        if (f3 == 5) begin
          e.legal = (f7 == 0 || f7 == 'h20);
          if (f7 == 'h20) e.b.alu_op = 7;
        end
      end
      'h63: begin e.legal = !(f3 inside {2, 3}); e.imm = 2; e.b.branch = 1; e.b.alu_op = 1;
                  e.u1 = 1; e.u2 = 1; end
      'h6F: begin e.imm = 3; e.b.jump = 1; e.b.alu_src = 1; e.b.a_pc = 1; e.b.result_src = 2; wr = 1; end
      'h67: begin e.legal = (f3 == 0); e.b.jump = 1; e.b.alu_src = 1; e.b.result_src = 2;
                  wr = 1; e.u1 = 1; end
      'h37: begin e.imm = 4; e.b.alu_src = 1; e.b.alu_op = 10; wr = 1; end
      'h17: begin e.imm = 4; e.b.alu_src = 1; e.b.a_pc = 1; wr = 1; end
      default: e.legal = 0;
    endcase
    if (e.legal) begin
      e.b.valid     = 1;
      e.b.funct3    = f3;
      e.b.rd        = wr ? rd : 0;
      e.b.reg_write = wr && rd != 0;
    end else begin
      e.b = bubble(); e.u1 = 0; e.u2 = 0;
    end
    return e;
  endfunction

  // One clock of stimulus; the model advances and the expectation is queued.
  task automatic cycle(input logic [31:0] ins, input bit v, input bit h, input bit f, output bit acc);
    dec_t d;
    sb_t  r;
    bit   stall;
    @(negedge clk); #1;
    bus_if.instr_id = ins; bus_if.id_valid = v; bus_if.hold = h; bus_if.flush_id = f;
    d = ref_decode(ins);
    stall = v && pm[0].valid && pm[0].mem_read && pm[0].rd != 0 &&
            ((d.u1 && int'(ins[19:15]) == pm[0].rd) || (d.u2 && int'(ins[24:20]) == pm[0].rd));
    r.chk_stall = !f; r.stall = stall; r.illegal = v && !d.legal; r.imm = d.imm;
    if (!h) begin
      pm[2] = pm[1]; pm[1] = pm[0];
      pm[0] = (f || stall || !v || !d.legal) ? bubble() : d.b;
    end
    r.ex = pm[0]; r.mem = pm[1]; r.wb = pm[2];
    sbq.push_back(r);
    acc = !h && (f || !stall);
  endtask

  // Present an instruction until the pipeline takes it (stall retries).
  task automatic issue(input logic [31:0] ins);
    bit acc;
    acc = 0;
    for (int t = 0; t < 6 && !acc; t++) cycle(ins, 1'b1, 1'b0, 1'b0, acc);
    check("issue_accept", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) cycle(32'h0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_valid"}, bus_if.ex_valid, 0);
    check({tag, "_ex_mem_read"}, bus_if.ex_mem_read, 0);
    check({tag, "_ex_alu_op"}, bus_if.ex_alu_op, 0);
    check({tag, "_ex_rd"}, bus_if.ex_rd, 0);
    check({tag, "_mem_valid"}, bus_if.mem_valid, 0);
    check({tag, "_mem_mem_write"}, bus_if.mem_mem_write, 0);
    check({tag, "_mem_rd"}, bus_if.mem_rd, 0);
    check({tag, "_wb_valid"}, bus_if.wb_valid, 0);
    check({tag, "_wb_reg_write"}, bus_if.wb_reg_write, 0);
    check({tag, "_wb_result_src"}, bus_if.wb_result_src, 0);
    check({tag, "_wb_rd"}, bus_if.wb_rd, 0);
    check({tag, "_hazard_stall"}, bus_if.hazard_stall, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    bus_if.id_valid = 1'b0; bus_if.hold = 1'b0; bus_if.flush_id = 1'b0;
    rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) pm[s] = bubble();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 11))
      0, 1:    return {12'($urandom), rs1, f3, rd, 7'h03};
      2:       return {f7, rs2, rs1, f3, 5'($urandom), 7'h23};
      3, 4:    return {f7, rs2, rs1, f3, rd, 7'h33};
      5:       return {f7, rs2, rs1, f3, rd, 7'h13};
      6:       return {f7, rs2, rs1, f3, 5'($urandom), 7'h63};
      7:       return {20'($urandom), rd, 7'h6F};
      8:       return {12'($urandom), rs1, f3, rd, 7'h67};
      9:       return {20'($urandom), rd, 7'h37};
      10:      return {20'($urandom), rd, 7'h17};
      default: return $urandom;
    endcase
  endfunction

  // Monitor: combinational ID outputs mid-cycle, stage registers after the edge.
  initial begin : monitor
    sb_t r;
    forever begin
      @(negedge clk); #2;
      if (sbq.size() != 0) begin
        r = sbq[0];
        check("id_illegal", bus_if.id_illegal, r.illegal);
        check("id_imm_src", bus_if.id_imm_src, r.imm);
        if (r.chk_stall) check("hazard_stall", bus_if.hazard_stall, r.stall);
        @(posedge clk); #1;
        r = sbq.pop_front();
        check("ex_valid", bus_if.ex_valid, r.ex.valid);
        check("ex_alu_src", bus_if.ex_alu_src, r.ex.alu_src);
        check("ex_alu_a_pc", bus_if.ex_alu_a_pc, r.ex.a_pc);
        check("ex_branch", bus_if.ex_branch, r.ex.branch);
        check("ex_jump", bus_if.ex_jump, r.ex.jump);
        check("ex_mem_read", bus_if.ex_mem_read, r.ex.mem_read);
        check("ex_alu_op", bus_if.ex_alu_op, r.ex.alu_op);
        check("ex_funct3", bus_if.ex_funct3, r.ex.funct3);
        check("ex_rd", bus_if.ex_rd, r.ex.rd);
        check("mem_valid", bus_if.mem_valid, r.mem.valid);
        check("mem_mem_read", bus_if.mem_mem_read, r.mem.mem_read);
        check("mem_mem_write", bus_if.mem_mem_write, r.mem.mem_write);
        check("mem_rd", bus_if.mem_rd, r.mem.rd);
        check("wb_valid", bus_if.wb_valid, r.wb.valid);
        check("wb_reg_write", bus_if.wb_reg_write, r.wb.reg_write);
        check("wb_result_src", bus_if.wb_result_src, r.wb.result_src);
        check("wb_rd", bus_if.wb_rd, r.wb.rd);
      end
    end
  end

  initial begin : driver
    bit          acc;
    logic [31:0] cur;
    bit          v, h, f;
    rst_n = 1'b0;
    bus_if.instr_id = '0; bus_if.id_valid = 1'b0; bus_if.hold = 1'b0; bus_if.flush_id = 1'b0;
    for (int s = 0; s < 3; s++) pm[s] = bubble();
    repeat (2) @(negedge clk);
    #1 check_all_zero("por");
    @(negedge clk); #1 rst_n = 1'b1;

    // add x3,x1,x2 flowing to WB
    issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33});
    idle(3);
    // lw x5,0(x1) ; add x6,x5,x2 -> one stall
    issue({12'd0, 5'd1, 3'd2, 5'd5, 7'h03});
    issue({7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33});
    // lw x0 ; add x6,x0,x2 -> no stall
    issue({12'd0, 5'd1, 3'd2, 5'd0, 7'h03});
    issue({7'h00, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33});
    idle(1);
    // beq x1,x2 then squash the following instruction
    issue({7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63});
    cycle({7'h00, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33}, 1'b1, 1'b0, 1'b1, acc);
    idle(2);
    // sw x2,0(x1) into MEM, then held for three cycles with flush asserted
    issue({7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'h23});
    cycle({7'h00, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33}, 1'b1, 1'b0, 1'b0, acc);
    repeat (3) cycle({7'h00, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33}, 1'b1, 1'b1, 1'b1, acc);
    idle(2);
    // lui, auipc, sra, illegal opcode, mul
    issue({20'h12345, 5'd7, 7'h37});
    issue({20'h00001, 5'd8, 7'h17});
    issue({7'h20, 5'd3, 5'd2, 3'b101, 5'd1, 7'h33});
    issue(32'h0000007F);
    issue({7'h01, 5'd3, 5'd2, 3'b000, 5'd1, 7'h33});
    // reset mid-stream with a valid add sitting in EX
    issue({12'd0, 5'd1, 3'd2, 5'd5, 7'h03});
    issue({7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33});
    pulse_reset();
    idle(1);

    // Randomized traffic with holds, flushes and idle slots.
    cur = rand_instr();
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 9) != 0);
      h = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 9) == 0);
      cycle(cur, v, h, f, acc);
      if (acc || !v) cur = rand_instr();
      if (n == 200) pulse_reset();
    end
    idle(4);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
